// File: rtl/serial_add_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_add_pkg                                             |
// | Description : Shared types and constants for the bit-serial adder        |
// |               sequencer: FSM state encoding, default operand width and   |
// |               a majority helper for the carry.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package serial_add_pkg;

  // Default operand/sum width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Sequencer states. The encoding is fixed so the state bits can be probed
  // directly on a logic analyser.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Carry-out of a single-bit full adder.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_full_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_full_adder                                          |
// | Description : Purely combinational 1-bit full adder.                     |
// |   x, y  in  1   addend bits                                              |
// |   ci    in  1   carry-in                                                 |
// |   s     out 1   sum bit  (x ^ y ^ ci)                                    |
// |   co    out 1   carry-out (majority of x, y, ci)                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_full_adder
  import serial_add_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = majority(x, y, ci);

endmodule : serial_full_adder
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_add_sequencer                                       |
// | Description : Self-timed sequencer for a bit-serial adder. Captures two  |
// |               WIDTH-bit operands and a carry-in on an accepted start,    |
// |               adds them LSB-first over WIDTH cycles and registers the    |
// |               result with a one-cycle done pulse.                        |
// |   clk    in  1      rising-edge clock                                    |
// |   rst    in  1      asynchronous active-high reset                       |
// |   start  in  1      request, sampled only while ready                    |
// |   a, b   in  WIDTH  operands, captured on the accepted start edge        |
// |   cin    in  1      carry-in, captured on the accepted start edge        |
// |   ready  out 1      high in IDLE                                         |
// |   busy   out 1      high in SHIFT                                        |
// |   done   out 1      high for the single DONE cycle                       |
// |   sum    out WIDTH  registered result, held until the next completion    |
// |   cout   out 1      registered final carry, held with sum                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  // Single shared full adder fed by the operand LSBs and the carry flop.
  serial_full_adder u_fa (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // New sum bit enters at the MSB; after WIDTH shifts the first bit computed
  // has walked down to bit 0. The discarded LSB falls off the shift.
  assign w_acc_next = WIDTH'({w_s, r_acc} >> 1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shifters, carry, accumulator, counter and result.
  // Operands are only loaded from IDLE, so input changes while busy are inert.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_co;
          r_acc   <= w_acc_next;
          // Hold the counter on the final shift so it never wraps when
          // WIDTH is a power of two.
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_sum  <= w_acc_next;
            r_cout <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decode registered state only.
  assign ready = (r_state == IDLE);
  assign busy  = (r_state == SHIFT);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule : serial_add_sequencer
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_add_sequencer                                    |
// | Description : Directed self-checking bench for serial_add_sequencer.     |
// |               An 8-bit and a 4-bit instance share clock and reset.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_add_sequencer;

  logic       clk;
  logic       rst;

  logic       start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, ready4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int assertions;
  int failures;

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_sequencer #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .ready (ready4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start pulse to the 8-bit instance and waits (bounded) for done.
  // Returns at the negedge where done is high. No comparisons here.
  task automatic do_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         output int busy_cnt, output bit got_done);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (busy8) busy_cnt++;
      if (done8) got_done = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    assertions++;
    if ({ready8, busy8, done8, sum8, cout8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: rdy/busy/done/sum/cout=%b/%b/%b/%h/%b required 1/0/0/00/0",
               ready8, busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_add;
    int bc; bit gd;
    do_add8(8'h35, 8'h1A, 1'b0, bc, gd);
    assertions++;
    if (!gd || bc != 8) begin
      failures++;
      $display("FAIL basic_latency: done=%0d busy_cycles=%0d required 1 and 8", gd, bc);
    end
    assertions++;
    if ({cout8, sum8} !== 9'h04F) begin
      failures++;
      $display("FAIL basic_sum: cout/sum=%b/%h required 0/4f", cout8, sum8);
    end
    @(negedge clk);
    assertions++;
    if (done8 !== 1'b0 || ready8 !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%b ready=%b required 0 and 1", done8, ready8);
    end
  endtask

  task automatic test_carry_chain;
    int bc; bit gd;
    do_add8(8'hFF, 8'h01, 1'b0, bc, gd);
    assertions++;
    if (!gd || {cout8, sum8} !== 9'h100) begin
      failures++;
      $display("FAIL carry_ff_01: done=%0d cout/sum=%b/%h required 1/00", gd, cout8, sum8);
    end
    do_add8(8'hFF, 8'hFF, 1'b1, bc, gd);
    assertions++;
    if (!gd || {cout8, sum8} !== 9'h1FF) begin
      failures++;
      $display("FAIL carry_ff_ff_1: done=%0d cout/sum=%b/%h required 1/ff", gd, cout8, sum8);
    end
  endtask

  // Reset during SHIFT after a nonzero result: outputs clear asynchronously.
  task automatic test_mid_reset;
    bit seen_done;
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h1A; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    assertions++;
    if ({ready8, busy8, done8, sum8, cout8} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: rdy/busy/done/sum/cout=%b/%b/%b/%h/%b required 1/0/0/00/0",
               ready8, busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen_done = 1'b1;
    end
    assertions++;
    if (seen_done) begin
      failures++;
      $display("FAIL mid_reset_no_done: activity seen after reset, required none");
    end
  endtask

  task automatic test_abort_recover;
    bit seen_done;
    int bc; bit gd;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen_done = 1'b1;
    end
    assertions++;
    if (seen_done || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: done_seen=%0d cout/sum=%b/%h required 0 0/00",
               seen_done, cout8, sum8);
    end
    do_add8(8'h80, 8'h80, 1'b0, bc, gd);
    assertions++;
    if (!gd || {cout8, sum8} !== 9'h100) begin
      failures++;
      $display("FAIL abort_recover: done=%0d cout/sum=%b/%h required 1/00", gd, cout8, sum8);
    end
  endtask

  // start held high; operands zeroed during SHIFT so the second op sees 0+0+1.
  task automatic test_back_to_back;
    int t1, t2, ndone;
    logic [8:0] r1, r2;
    logic [8:0] held;
    bit cleared;
    t1 = -1; t2 = -1; ndone = 0; cleared = 1'b0;
    r1 = '0; r2 = '0; held = '0;
    @(negedge clk);
    a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1; start8 = 1'b1;
    for (int cyc = 0; cyc < 40 && ndone < 2; cyc++) begin
      @(negedge clk);
      if (busy8 && !cleared) begin
        a8 = 8'h00; b8 = 8'h00; cleared = 1'b1;
      end
      if (ndone == 1 && cyc == t1 + 3) held = {cout8, sum8};
      if (done8) begin
        if (ndone == 0) begin t1 = cyc; r1 = {cout8, sum8}; end
        else begin t2 = cyc; r2 = {cout8, sum8}; start8 = 1'b0; end
        ndone++;
      end
    end
    start8 = 1'b0;
    assertions++;
    if (ndone != 2 || (t2 - t1) != 10) begin
      failures++;
      $display("FAIL b2b_spacing: done_count=%0d spacing=%0d required 2 and 10", ndone, t2 - t1);
    end
    assertions++;
    if (r1 !== 9'h12D) begin
      failures++;
      $display("FAIL b2b_first_result: cout/sum=%h required 12d", r1);
    end
    assertions++;
    if (held !== 9'h12D) begin
      failures++;
      $display("FAIL b2b_result_hold: cout/sum during next op=%h required 12d", held);
    end
    assertions++;
    if (r2 !== 9'h001) begin
      failures++;
      $display("FAIL b2b_second_result: cout/sum=%h required 001", r2);
    end
    repeat (3) @(negedge clk);
    assertions++;
    if (ready8 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: ready=%b required 1", ready8);
    end
  endtask

  task automatic test_width4;
    int bc; bit gd;
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    bc = 0; gd = 1'b0;
    for (int i = 0; i < 12 && !gd; i++) begin
      if (busy4) bc++;
      if (done4) gd = 1'b1;
      else @(negedge clk);
    end
    assertions++;
    if (!gd || bc != 4) begin
      failures++;
      $display("FAIL w4_latency: done=%0d busy_cycles=%0d required 1 and 4", gd, bc);
    end
    assertions++;
    if ({cout4, sum4} !== 5'h11) begin
      failures++;
      $display("FAIL w4_sum: cout/sum=%b/%h required 1/1", cout4, sum4);
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    rst = 1'b1;

    test_reset();
    test_basic_add();
    test_carry_chain();
    test_mid_reset();
    test_abort_recover();
    test_back_to_back();
    test_width4();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule : tb_serial_add_sequencer
`default_nettype wire

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Control and datapath sequencer for the bit-serial adder. It captures two WIDTH-bit operands on a start handshake, shifts them LSB-first through a single-bit full adder for exactly WIDTH clock cycles, and accumulates the sum in a shift register. It then presents the registered result with a one-cycle done pulse. It sits between the operand source and the single-bit shift/adder datapath, replacing hand-clocked stimulus with a self-timed sequence.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT only.
- done  output  1  one-cycle pulse, high in DONE only.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered final carry; holds with sum.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE -> SHIFT on a clock edge where start=1.
  - At that edge: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0.
- SHIFT, each edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - acc <= {s, acc[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1; cnt increments.
- On the SHIFT edge where cnt==WIDTH-1:
  - sum <= {s, acc[WIDTH-1:1]}; cout <= majority(...).
  - Go to DONE.
- DONE -> IDLE unconditionally after one cycle.
- start is ignored in SHIFT and DONE. Operand changes while busy have no effect.
- cnt is $clog2(WIDTH) bits wide and never wraps within an operation.
- Arithmetic is {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).
- Reset, including mid-operation:
  - state=IDLE, cnt=0, carry=0, a_sr/b_sr/acc=0, sum=0, cout=0.
  - Reset outputs: ready=1, busy=0, done=0.
  - An aborted operation never produces done. sum/cout return to 0, not to the prior result.

## Timing
- ready, busy and done are decoded combinationally from registered state. They are glitch-free state bits, not combinational from inputs.
- Latency: start is accepted at edge k. Shifts occur at edges k+1 … k+WIDTH.
  - done=1 during the cycle after edge k+WIDTH.
  - sum/cout are valid from edge k+WIDTH onward.
- Throughput: the next start can be accepted at edge k+WIDTH+2, i.e. the first IDLE cycle. That is one operation per WIDTH+2 cycles.
- sum/cout change only at the final SHIFT edge or on reset. They are stable throughout IDLE, the next SHIFT, and DONE.

## Structure
- Shared package serial_add_pkg:
  - State typedef: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- Sub-module serial_full_adder: combinational 1-bit full adder, (x, y, ci) -> (s, co). It is instantiated once, and a testbench can reuse it standalone.
- All state lives in the top: FSM, counter, operand shift registers, carry flop, and result registers.

## Test plan
- Reset: pulse rst while SHIFT is in progress -> within the same cycle ready=1, busy=0, done=0, sum=0, cout=0. No done follows.
- Basic add: a=8'h35, b=8'h1A, cin=0, start for 1 cycle -> busy for exactly 8 cycles, then done for 1 cycle; sum=8'h4F, cout=0.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Handshake:
  - Hold start=1 continuously, and change a/b to 8'h00 during SHIFT -> the first result still reflects the captured operands.
  - A second operation starts on the first IDLE cycle; done pulses are spaced exactly 10 cycles apart.
- Abort and recover: assert rst at the 4th SHIFT cycle of a=8'h80, b=8'h80 -> no done. A following add of a=8'h80, b=8'h80 gives sum=8'h00, cout=1.
- Parameter check, WIDTH=4: a=4'h9, b=4'h8, cin=0 -> done 4 cycles after acceptance; sum=4'h1, cout=1.
